// File: rtl/fdiv_sched.sv
// fdiv_sched: round-robin scheduler sharing one multicycle FP divide datapath
module fdiv_sched #(
  parameter int N   = 32,
  parameter int REQ = 4,
  parameter int LAT = 4,
  parameter int IDW = $clog2(REQ)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REQ-1:0]   req_valid,
  output logic [REQ-1:0]   req_ready,
  input  logic [REQ*N-1:0] req_a,
  input  logic [REQ*N-1:0] req_b,
  output logic [N-1:0]     div_a,
  output logic [N-1:0]     div_b,
  input  logic [N-1:0]     div_out,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [N-1:0]     rsp_data,
  output logic [IDW-1:0]   rsp_id,
  output logic             rsp_dbz,
  output logic             busy
);
  localparam int EW = N == 64 ? 11 : 8;
  localparam int CW = $clog2(LAT + 1);
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  state_t state, state_nx;
  logic [IDW-1:0] last_grant, grant;
  logic [CW-1:0] cnt;
  logic [N-1:0] sel_a, sel_b;
  logic hit, sel_zero;
  int idx;
  always_comb begin
    grant = last_grant;
    hit = 1'b0;
    idx = 0;
    for (int k = 1; k <= REQ; k++) begin
      idx = (int'(last_grant) + k) % REQ;
      if (!hit && req_valid[idx]) begin
        hit = 1'b1;
        grant = IDW'(idx);
      end
    end
  end
  assign sel_a = req_a[int'(grant)*N +: N];
  assign sel_b = req_b[int'(grant)*N +: N];
  assign sel_zero = sel_b[N-2:0] == '0;
  // ready is gated by rst_n so a held request never shows accept during reset
  assign req_ready = (rst_n && state == IDLE && hit) ? REQ'(1) << grant : '0;
  assign rsp_valid = state == RESP;
  assign busy = state != IDLE;
  always_comb begin
    state_nx = state == IDLE ? (hit ? (sel_zero ? RESP : BUSY) : IDLE)
             : state == BUSY ? (cnt == '0 ? RESP : BUSY)
             : (rsp_ready ? IDLE : RESP);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      last_grant <= IDW'(REQ - 1);
      cnt <= '0;
      div_a <= '0;
      div_b <= '0;
      rsp_data <= '0;
      rsp_id <= '0;
      rsp_dbz <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && hit) begin
        last_grant <= grant;
        rsp_id <= grant;
        div_a <= sel_a;
        div_b <= sel_b;
        rsp_dbz <= sel_zero;
        cnt <= CW'(LAT - 1);
        if (sel_zero) rsp_data <= {sel_a[N-1] ^ sel_b[N-1], {EW{1'b1}}, {(N-1-EW){1'b0}}};
      end
      if (state == BUSY) begin
        cnt <= cnt - CW'(1);
        if (cnt == '0) rsp_data <= div_out;
      end
    end
  end
endmodule
